activation_feeder: RTL and testbench

ACTIVATION_FEEDER -- requirements
Module: activation_feeder

---
 rtl/activation_feeder_pkg.sv | 24 ++
 rtl/activation_feeder_skew_line.sv | 26 ++
 rtl/activation_feeder.sv | 149 ++++++++++++++
 tb/tb_activation_feeder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/activation_feeder_pkg.sv
// Shared definitions for the PE-array activation feeder: array width defaults,
// the job-sequencing state encoding and the drain length.
package activation_feeder_pkg;

  localparam int ROWS_DEFAULT        = 4;
  localparam int COLS_DEFAULT        = 4;
  localparam int DATA_WIDTH_DEFAULT  = 4;
  localparam int COUNT_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WLOAD,
    ST_LPULSE,
    ST_STREAM,
    ST_DRAIN,
    ST_FIN
  } state_t;

  // Cycles needed after the last vector for skewed data to cross the array.
  function automatic int drain_len(input int rows, input int cols);
    return rows + cols - 2;
  endfunction

endpackage

// File: rtl/activation_feeder_skew_line.sv
// Fixed-depth delay line for one activation lane; flush forces every stage to zero.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/activation_feeder.sv
// Loads a weight matrix into a systolic PE array, then streams K activation
// vectors through a per-row skew so row r sees its data r cycles after row 0.
module activation_feeder
  import activation_feeder_pkg::*;
#(
  parameter int ROWS               = ROWS_DEFAULT,
  parameter int COLS               = COLS_DEFAULT,
  parameter int COMPUTE_DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int COUNT_WIDTH        = COUNT_WIDTH_DEFAULT
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [COUNT_WIDTH-1:0]                  num_vectors,
  input  logic                                    w_valid,
  output logic                                    w_ready,
  input  logic [ROWS*COMPUTE_DATA_WIDTH-1:0]      w_data,
  input  logic                                    act_valid,
  output logic                                    act_ready,
  input  logic [ROWS*COMPUTE_DATA_WIDTH-1:0]      act_data,
  output logic [ROWS*COMPUTE_DATA_WIDTH-1:0]      data_out,
  output logic [ROWS*COLS*COMPUTE_DATA_WIDTH-1:0] weights_out,
  output logic                                    load_en,
  output logic                                    compute,
  output logic                                    busy,
  output logic                                    done
);

  localparam int W         = COMPUTE_DATA_WIDTH;
  localparam int DRAIN_LEN = drain_len(ROWS, COLS);
  localparam int WCW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DCW       = 16;

  state_t                 state_reg, state_next;
  logic [COUNT_WIDTH-1:0] k_reg;
  logic [COUNT_WIDTH-1:0] a_cnt_reg;
  logic [WCW-1:0]         w_cnt_reg;
  logic [DCW-1:0]         d_cnt_reg;
  logic [ROWS*W-1:0]      w_bank_reg [COLS];

  logic              w_fire;
  logic              act_fire;
  logic              flush;
  logic [ROWS*W-1:0] skew_in;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    w_ready    = 1'b0;
    act_ready  = 1'b0;
    load_en    = 1'b0;
    compute    = 1'b0;
    done       = 1'b0;
    busy       = (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_WLOAD;
      end
      ST_WLOAD: begin
        w_ready = 1'b1;
        if (w_valid && w_cnt_reg == WCW'(COLS - 1)) state_next = ST_LPULSE;
      end
      ST_LPULSE: begin
        load_en    = 1'b1;
        state_next = (k_reg != '0) ? ST_STREAM : ST_FIN;
      end
      ST_STREAM: begin
        act_ready = (a_cnt_reg < k_reg);
        compute   = 1'b1;
        if (act_valid && a_cnt_reg == k_reg - COUNT_WIDTH'(1))
          state_next = (DRAIN_LEN > 0) ? ST_DRAIN : ST_FIN;
      end
      ST_DRAIN: begin
        compute = 1'b1;
        if (d_cnt_reg == DCW'(DRAIN_LEN - 1)) state_next = ST_FIN;
      end
      ST_FIN: begin
        done       = 1'b1;
        // A weight-load-only job never raises compute.
        compute    = (k_reg != '0);
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (rst) begin
      state_next = ST_IDLE;
      w_ready    = 1'b0;
      act_ready  = 1'b0;
      load_en    = 1'b0;
      compute    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
    end
  end

  assign w_fire   = w_valid & w_ready;
  assign act_fire = act_valid & act_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg     <= '0;
      w_cnt_reg <= '0;
      a_cnt_reg <= '0;
      d_cnt_reg <= '0;
      for (int c = 0; c < COLS; c++) w_bank_reg[c] <= '0;
    end else begin
      if (state_reg == ST_IDLE && start) begin
        k_reg     <= num_vectors;
        w_cnt_reg <= '0;
        a_cnt_reg <= '0;
        d_cnt_reg <= '0;
      end
      if (w_fire) begin
        w_bank_reg[w_cnt_reg] <= w_data;
        w_cnt_reg             <= w_cnt_reg + 1'b1;
      end
      if (act_fire)              a_cnt_reg <= a_cnt_reg + 1'b1;
      if (state_reg == ST_DRAIN) d_cnt_reg <= d_cnt_reg + 1'b1;
    end
  end

  // Bubbles and drain cycles push zeros so the array never sees stale data.
  assign skew_in = act_fire ? act_data : '0;
  assign flush   = !(state_reg == ST_STREAM || state_reg == ST_DRAIN);

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_wcol
      assign weights_out[gi*ROWS*W +: ROWS*W] = w_bank_reg[gi];
    end
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      skew_line #(
        .DEPTH (gi + 1),
        .WIDTH (W)
      ) u_skew (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .din   (skew_in[gi*W +: W]),
        .dout  (data_out[gi*W +: W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_activation_feeder.sv
// Scoreboard bench for activation_feeder at ROWS=COLS=2, W=4: jobs push their
// expected load/data/done events, a negedge monitor pops and compares them.
module tb_activation_feeder;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int W    = 4;
  localparam int CW   = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [CW-1:0]          num_vectors = '0;
  logic                   w_valid = 1'b0;
  logic                   w_ready;
  logic [ROWS*W-1:0]      w_data = '0;
  logic                   act_valid = 1'b0;
  logic                   act_ready;
  logic [ROWS*W-1:0]      act_data = '0;
  logic [ROWS*W-1:0]      data_out;
  logic [ROWS*COLS*W-1:0] weights_out;
  logic                   load_en;
  logic                   compute;
  logic                   busy;
  logic                   done;

  activation_feeder #(
    .ROWS               (ROWS),
    .COLS               (COLS),
    .COMPUTE_DATA_WIDTH (W),
    .COUNT_WIDTH        (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_vectors (num_vectors),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_data      (w_data),
    .act_valid   (act_valid),
    .act_ready   (act_ready),
    .act_data    (act_data),
    .data_out    (data_out),
    .weights_out (weights_out),
    .load_en     (load_en),
    .compute     (compute),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0;
  int load_cyc = 0;
  int last_beat_cyc = 0;
  int beats_job = 0;
  int done_seen = 0;
  int act_seen = 0;
  int compute_seen = 0;

  logic [15:0] exp_w[$];
  int          exp_delay[$];
  logic [7:0]  exp_data[$];
  int          exp_done[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected or missing event, expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    int ed;
    if (w_valid && w_ready) begin
      beats_job++;
      last_beat_cyc = cyc;
    end
    if (done)      done_seen++;
    if (act_ready) act_seen++;
    if (compute)   compute_seen++;
    if (load_en) begin
      if (exp_w.size() == 0) fail_now("load_unexpected");
      else begin
        ed = exp_delay.pop_front();
        check("weights_at_load", 64'(weights_out), 64'(exp_w.pop_front()));
        check("beats_before_load", 64'(beats_job), 64'(COLS));
        check("load_after_last_beat", 64'(cyc - last_beat_cyc), 64'(1));
        if (ed >= 0) check("load_latency", 64'(cyc - start_cyc), 64'(ed));
      end
      load_cyc = cyc;
    end
    if (compute) begin
      if (exp_data.size() == 0) fail_now("compute_unexpected");
      else check("data_out", 64'(data_out), 64'(exp_data.pop_front()));
    end else if (busy) begin
      check("data_out_zero_no_compute", 64'(data_out), 64'(0));
    end
    if (done) begin
      if (exp_done.size() == 0) fail_now("done_unexpected");
      else check("done_after_load", 64'(cyc - load_cyc), 64'(exp_done.pop_front()));
    end
  end

  // exp_seq holds the data_out value of each compute cycle, byte t = cycle t.
  task automatic run_job(input string tag, input int k, input logic [15:0] wcols,
                         input logic [23:0] vecs, input int bubble_after, input int bubble_len,
                         input bit w_stall, input bit noisy, input bit abort,
                         input logic [63:0] exp_seq, input int n_exp, input int done_off);
    int d0, a0, c0, n;
    d0 = done_seen;
    a0 = act_seen;
    c0 = compute_seen;
    exp_w.push_back(wcols);
    exp_delay.push_back(w_stall ? -1 : 3);
    for (int t = 0; t < n_exp; t++) exp_data.push_back(exp_seq[t*8 +: 8]);
    exp_done.push_back(done_off);

    @(posedge clk); #1;
    start       = 1'b1;
    num_vectors = CW'(k);
    start_cyc   = cyc;
    beats_job   = 0;
    @(posedge clk); #1;
    start = 1'b0;

    for (int j = 0; j < COLS; j++) begin
      if (w_stall) begin
        for (int s = 0; s < 4 && $urandom_range(0, 1) == 1; s++) begin
          w_valid = 1'b0;
          w_data  = 8'hEE;
          @(posedge clk); #1;
        end
      end
      w_valid = 1'b1;
      w_data  = wcols[j*8 +: 8];
      n = 0;
      while (!w_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (!w_ready) fail_now("w_ready_timeout");
      @(posedge clk); #1;
    end
    w_valid = noisy;
    w_data  = 8'hDD;

    if (k > 0) begin
      n = 0;
      while (!act_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      for (int i = 0; i < k; i++) begin
        act_valid = 1'b1;
        act_data  = vecs[i*8 +: 8];
        if (noisy && i == 1) start = 1'b1;
        check("act_ready_in_stream", 64'(act_ready), 64'(1));
        @(posedge clk); #1;
        start = 1'b0;
        if (i == bubble_after) begin
          for (int b = 0; b < bubble_len; b++) begin
            act_valid = 1'b0;
            act_data  = 8'hFF;
            @(posedge clk); #1;
          end
        end
      end
      act_valid = noisy;
      act_data  = 8'hFF;
    end

    if (abort) begin
      check("compute_in_drain", 64'(compute), 64'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_data_out", 64'(data_out), 64'(0));
      check("abort_weights_out", 64'(weights_out), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      exp_data.delete();
      exp_done.delete();
      repeat (6) @(posedge clk);
      #1;
      check("no_done_after_abort", 64'(done_seen - d0), 64'(0));
      $display("job %s: aborted in drain", tag);
      return;
    end

    n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) fail_now("job_timeout");
    check("done_count", 64'(done_seen - d0), 64'(1));
    check("data_events_left", 64'(exp_data.size()), 64'(0));
    check("done_events_left", 64'(exp_done.size()), 64'(0));
    check("weights_hold", 64'(weights_out), 64'(wcols));
    if (k == 0) begin
      check("act_ready_k0", 64'(act_seen - a0), 64'(0));
      check("compute_k0", 64'(compute_seen - c0), 64'(0));
    end
    if (noisy) begin
      repeat (3) @(posedge clk);
      #1;
      check("no_restart", 64'(busy), 64'(0));
    end
    w_valid   = 1'b0;
    act_valid = 1'b0;
    $display("job %s: K=%0d weights=%h finished", tag, k, wcols);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_load_en", 64'(load_en), 64'(0));
    check("reset_compute", 64'(compute), 64'(0));
    check("reset_ready", 64'({w_ready, act_ready}), 64'(0));
    check("reset_data_out", 64'(data_out), 64'(0));
    check("reset_weights_out", 64'(weights_out), 64'(0));
    rst = 1'b0;

    run_job("basic", 3, 16'h4321, 24'h654321, -1, 0, 1'b0, 1'b0, 1'b0,
            64'h0000_0060_4523_0100, 6, 6);
    run_job("bubble", 3, 16'h4321, 24'h654321, 0, 2, 1'b0, 1'b0, 1'b0,
            64'h0060_4503_0020_0100, 8, 8);
    run_job("k0", 0, 16'h8765, 24'h000000, -1, 0, 1'b0, 1'b0, 1'b0,
            64'h0, 0, 1);
    run_job("start_mid", 3, 16'hC3B2, 24'h3C8AF7, -1, 0, 1'b0, 1'b1, 1'b0,
            64'h0000_0030_8CFA_0700, 6, 6);
    run_job("abort", 2, 16'h7E1D, 24'h003412, -1, 0, 1'b0, 1'b0, 1'b1,
            64'h0000_0000_3014_0200, 5, 5);
    run_job("after_abort", 3, 16'h4321, 24'h654321, -1, 0, 1'b0, 1'b0, 1'b0,
            64'h0000_0060_4523_0100, 6, 6);
    run_job("stall_a", 1, 16'h9C4D, 24'h000021, -1, 0, 1'b1, 1'b0, 1'b0,
            64'h0000_0000_0020_0100, 4, 4);
    run_job("stall_b", 1, 16'h0FF0, 24'h000021, -1, 0, 1'b1, 1'b0, 1'b0,
            64'h0000_0000_0020_0100, 4, 4);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000ns");
    $fatal(1);
  end

endmodule
